// File: rtl/fetch_control_if.sv
// Fetch-unit signal bundle: hazard/branch inputs and PC/flush outputs.
// master = fetch_control side, slave = pipeline/memory side.
interface fetch_control_if;
    logic        stall;
    logic        hlt;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] instr_mem_data;
    logic [15:0] pc;
    logic        fetch_valid;
    logic        flush_ifid;
    logic        flush_idex;
    logic [15:0] redirect_count;

    modport master (
        input  stall, hlt, branch_taken, branch_target, instr_mem_data,
        output pc, fetch_valid, flush_ifid, flush_idex, redirect_count
    );

    modport slave (
        output stall, hlt, branch_taken, branch_target, instr_mem_data,
        input  pc, fetch_valid, flush_ifid, flush_idex, redirect_count
    );
endinterface

// File: rtl/fetch_control.sv
// PC register and fetch-redirect unit with branch shadow, stall and HLT handling.
// Optional feature macro: RESET_VECTOR_EN (boot PC loaded from the word at RESET_PC).
module fetch_control #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int unsigned SHADOW_DEPTH = 2
) (
    input logic             clk,
    input logic             rst,
    fetch_control_if.master bus
);

`ifdef RESET_VECTOR_EN
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    localparam state_t RESET_STATE = BOOT;
`else
    typedef enum logic [1:0] {RUN, HALT} state_t;
    localparam state_t RESET_STATE = RUN;
`endif

    localparam logic [1:0] SHADOW_INIT = SHADOW_DEPTH[1:0];

    state_t      state;
    state_t      state_next;
    logic [15:0] pc_q;
    logic [15:0] redirect_count_q;
    logic [1:0]  shadow_cnt;
    logic        accept;

    always_ff @(posedge clk) begin
        if (rst) state <= RESET_STATE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
`ifdef RESET_VECTOR_EN
            BOOT:    state_next = RUN;
`endif
            RUN:     if (!accept && bus.hlt) state_next = HALT;
            default: state_next = state;
        endcase
    end

    always_comb begin
        accept          = (state == RUN) && bus.branch_taken && (shadow_cnt == 2'd0);
        bus.flush_ifid  = accept;
        bus.flush_idex  = accept;
        bus.fetch_valid = (state == RUN);
    end

    // A taken redirect outranks hlt/stall: those belong to squashed younger instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            redirect_count_q <= '0;
            shadow_cnt       <= '0;
        end else begin
            case (state)
`ifdef RESET_VECTOR_EN
                BOOT: pc_q <= bus.instr_mem_data;
`endif
                RUN: begin
                    if (accept) begin
                        pc_q             <= bus.branch_target;
                        shadow_cnt       <= SHADOW_INIT;
                        redirect_count_q <= redirect_count_q + 16'd1;
                    end else begin
                        if (shadow_cnt != 2'd0) shadow_cnt <= shadow_cnt - 2'd1;
                        if (!bus.hlt && !bus.stall) pc_q <= pc_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc             = pc_q;
    assign bus.redirect_count = redirect_count_q;

endmodule

// File: tb/tb_fetch_control.sv
// Directed self-checking bench for fetch_control (default build, or RESET_VECTOR_EN boot path).
module tb_fetch_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_rc = '0;

    always #5 clk = ~clk;

    fetch_control_if bus ();

    fetch_control #(.RESET_PC(16'h0000), .SHADOW_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory: reset vector word at address 0
    always_comb bus.instr_mem_data = (bus.pc == 16'h0000) ? 16'h0020 : 16'hDEAD;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall = 1'b0;
        bus.hlt = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 16'h0000;
    endtask

    // Accepted redirect to t-2 then two idle cycles; leaves pc=t with shadow cleared.
    task automatic redirect_to(input logic [15:0] t);
        bus.branch_taken = 1'b1;
        bus.branch_target = t - 16'd2;
        #1;
        check("redir_flush", {15'd0, bus.flush_ifid}, 16'd1);
        tick();
        exp_rc = exp_rc + 16'd1;
        bus.branch_taken = 1'b0;
        tick();
        tick();
        check("redir_pc", bus.pc, t);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rc = '0;
        check("rst_pc", bus.pc, 16'h0000);
        check("rst_rc", bus.redirect_count, 16'h0000);
`ifdef RESET_VECTOR_EN
        check("rst_fv", {15'd0, bus.fetch_valid}, 16'd0);
`else
        check("rst_fv", {15'd0, bus.fetch_valid}, 16'd1);
`endif
    endtask

    initial begin
        idle();
        // Reset and first fetches
        do_reset();
`ifdef RESET_VECTOR_EN
        tick();
        check("boot_pc0", bus.pc, 16'h0020);
        check("boot_fv", {15'd0, bus.fetch_valid}, 16'd1);
        tick();
        check("boot_pc1", bus.pc, 16'h0021);
        tick();
        check("boot_pc2", bus.pc, 16'h0022);
`else
        tick();
        check("seq_pc1", bus.pc, 16'h0001);
        tick();
        check("seq_pc2", bus.pc, 16'h0002);
`endif

        // Branch and shadow
        redirect_to(16'h0030);
        bus.branch_taken = 1'b1;
        bus.branch_target = 16'h0100;
        #1;
        check("br_flush_ifid", {15'd0, bus.flush_ifid}, 16'd1);
        check("br_flush_idex", {15'd0, bus.flush_idex}, 16'd1);
        tick();
        exp_rc = exp_rc + 16'd1;
        check("br_pc", bus.pc, 16'h0100);
        check("br_rc", bus.redirect_count, exp_rc);
        bus.branch_target = 16'h0500;
        #1;
        check("shadow_flush1", {15'd0, bus.flush_ifid}, 16'd0);
        tick();
        check("shadow_pc1", bus.pc, 16'h0101);
        tick();
        check("shadow_pc2", bus.pc, 16'h0102);
        check("shadow_rc", bus.redirect_count, exp_rc);
        idle();

        // Stall, then stall+branch
        redirect_to(16'h0040);
        bus.stall = 1'b1;
        tick();
        tick();
        tick();
        check("stall_pc", bus.pc, 16'h0040);
        check("stall_fv", {15'd0, bus.fetch_valid}, 16'd1);
        bus.branch_taken = 1'b1;
        bus.branch_target = 16'h0200;
        #1;
        check("stallbr_flush", {15'd0, bus.flush_idex}, 16'd1);
        tick();
        exp_rc = exp_rc + 16'd1;
        check("stallbr_pc", bus.pc, 16'h0200);
        // Shadow drains while stalled
        bus.branch_taken = 1'b0;
        tick();
        tick();
        check("stall_shadow_pc", bus.pc, 16'h0200);
        idle();
        redirect_to(16'h0048);

        // hlt+branch: branch wins, stays in RUN
        redirect_to(16'h0050);
        bus.hlt = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 16'h0060;
        #1;
        check("hltbr_flush", {15'd0, bus.flush_ifid}, 16'd1);
        tick();
        exp_rc = exp_rc + 16'd1;
        check("hltbr_pc", bus.pc, 16'h0060);
        check("hltbr_fv", {15'd0, bus.fetch_valid}, 16'd1);
        idle();
        tick();
        tick();
        check("hltbr_run_pc", bus.pc, 16'h0062);

        // Halt
        redirect_to(16'h0050);
        bus.hlt = 1'b1;
        tick();
        check("halt_pc", bus.pc, 16'h0050);
        check("halt_fv", {15'd0, bus.fetch_valid}, 16'd0);
        bus.hlt = 1'b0;
        bus.branch_taken = 1'b1;
        bus.branch_target = 16'h0999;
        #1;
        check("halt_flush", {15'd0, bus.flush_ifid}, 16'd0);
        for (int i = 0; i < 5; i++) tick();
        check("halt_pc_hold", bus.pc, 16'h0050);
        check("halt_fv_hold", {15'd0, bus.fetch_valid}, 16'd0);
        check("halt_rc_hold", bus.redirect_count, exp_rc);

        // Reset mid-shadow
        do_reset();
`ifdef RESET_VECTOR_EN
        tick();
`endif
        redirect_to(16'h0302);
        bus.branch_taken = 1'b1;
        bus.branch_target = 16'h0300;
        tick();
        check("preshadow_pc", bus.pc, 16'h0300);
        do_reset();
`ifdef RESET_VECTOR_EN
        tick();
`endif
        bus.branch_taken = 1'b1;
        bus.branch_target = 16'h0123;
        #1;
        check("postrst_flush", {15'd0, bus.flush_ifid}, 16'd1);
        tick();
        exp_rc = exp_rc + 16'd1;
        check("postrst_pc", bus.pc, 16'h0123);
        check("postrst_rc", bus.redirect_count, exp_rc);
        idle();
        tick();
        tick();

        // PC wrap
        redirect_to(16'hFFFF);
        tick();
        check("wrap_pc", bus.pc, 16'h0000);

        // Held branch_taken is accepted once every SHADOW_DEPTH+1 cycles
        bus.branch_taken = 1'b1;
        bus.branch_target = 16'h0777;
        for (int i = 0; i < 300; i++) begin
            tick();
            tick();
            tick();
        end
        exp_rc = exp_rc + 16'd300;
        check("burst_rc", bus.redirect_count, exp_rc);
        check("burst_pc", bus.pc, 16'h0779);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
